// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for the shared-adder arbiter.
// slave = arbiter side, master = requesters plus response consumer.
interface adder_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_sum;
  logic               rsp_cout;
  logic               rsp_of;
  logic [31:0]        ops_done;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum,
    output rsp_cout, rsp_of, ops_done
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum,
    input  rsp_cout, rsp_of, ops_done
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one 32-bit adder among NREQ
// requesters; result lands in a single registered response slot.
module adder_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int ADDER_SEL = 0
) (
  input logic                clk,
  input logic                rst,
  adder_share_arbiter_if.slave bus
);

  function automatic logic [32:0] add_rca(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        c
  );
    return {1'b0, a} + {1'b0, b} + {32'b0, c};
  endfunction

  // 4-bit lookahead groups, group carries rippled between groups
  function automatic logic [32:0] add_cla(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        c
  );
    logic [31:0] g, p;
    logic [32:0] cy;
    g = a & b;
    p = a ^ b;
    cy = '0;
    cy[0] = c;
    for (int k = 0; k < 8; k++) begin
      cy[4*k+1] = g[4*k]
        | (p[4*k] & cy[4*k]);
      cy[4*k+2] = g[4*k+1]
        | (p[4*k+1] & g[4*k])
        | (p[4*k+1] & p[4*k] & cy[4*k]);
      cy[4*k+3] = g[4*k+2]
        | (p[4*k+2] & g[4*k+1])
        | (p[4*k+2] & p[4*k+1] & g[4*k])
        | (p[4*k+2] & p[4*k+1] & p[4*k] & cy[4*k]);
      cy[4*k+4] = g[4*k+3]
        | (p[4*k+3] & g[4*k+2])
        | (p[4*k+3] & p[4*k+2] & g[4*k+1])
        | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
        | (&p[4*k+:4] & cy[4*k]);
    end
    return {cy[32], p ^ cy[31:0]};
  endfunction

  function automatic logic [32:0] add_csel(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        c
  );
    logic [16:0] lo, h0, h1;
    lo = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'b0, c};
    h0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    h1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
    return lo[16] ? {h1, lo[15:0]} : {h0, lo[15:0]};
  endfunction

  logic [IDW-1:0]  ptr, ptr_nxt, gnt_id, idx;
  logic [NREQ-1:0] grant;
  logic            found, slot_free;
  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];
  logic [31:0]     a_sel, b_sel, add_sum;
  logic            cin_sel, add_cout, add_of;
  logic [32:0]     add_res;

  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_sum, ops_done;
  logic            rsp_cout, rsp_of;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[32*i +: 32];
    assign b_arr[i] = bus.req_b[32*i +: 32];
  end

  assign slot_free = !rsp_valid || bus.rsp_ready;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    grant  = '0;
    if (slot_free && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = IDW'((int'(ptr) + k) % NREQ);
        if (!found && bus.req_valid[idx]) begin
          found  = 1'b1;
          gnt_id = idx;
        end
      end
    end
    grant[gnt_id] = found;
  end

  assign ptr_nxt = (int'(gnt_id) == NREQ - 1) ? '0
                 : gnt_id + IDW'(1);

  // gnt_id is 0 when nothing is granted; that result is dropped
  assign a_sel   = a_arr[gnt_id];
  assign b_sel   = b_arr[gnt_id];
  assign cin_sel = bus.req_cin[gnt_id];

  if (ADDER_SEL == 1) begin : g_cla
    assign add_res = add_cla(a_sel, b_sel, cin_sel);
  end else if (ADDER_SEL == 2) begin : g_csel
    assign add_res = add_csel(a_sel, b_sel, cin_sel);
  end else begin : g_rca
    assign add_res = add_rca(a_sel, b_sel, cin_sel);
  end

  assign add_sum  = add_res[31:0];
  assign add_cout = add_res[32];
  assign add_of   = (a_sel[31] == b_sel[31])
                 && (add_sum[31] != a_sel[31]);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_of    <= 1'b0;
      ptr       <= '0;
      ops_done  <= '0;
    end else begin
      if (found) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_id;
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_of    <= add_of;
        ptr       <= ptr_nxt;
      end else if (bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && bus.rsp_ready)
        ops_done <= ops_done + 32'd1;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_sum   = rsp_sum;
  assign bus.rsp_cout  = rsp_cout;
  assign bus.rsp_of    = rsp_of;
  assign bus.ops_done  = ops_done;

endmodule
